// File: rtl/enc128b130b_pkg.sv
// rtl/enc128b130b_pkg.sv - shared constants and helpers for the 128b/130b encode path
package enc128b130b_pkg;

  // Block framing
  localparam int BYTES_PER_BLK = 16;
  localparam int BYTE_W        = 8;
  localparam int HDR_W         = 2;
  localparam int BLK0_W        = BYTE_W + HDR_W;

  // Gearbox sizing
  localparam int BUF_W = 24;
  localparam int LVL_W = 5;
  localparam int POS_W = 4;

  // Sync header codes, bit 0 is sent first
  localparam logic [HDR_W-1:0] SYNC_DATA = 2'b10;
  localparam logic [HDR_W-1:0] SYNC_OS   = 2'b01;

  // True for the two header codes a receiver can lock onto
  function automatic logic hdr_legal(input logic [HDR_W-1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_OS);
  endfunction

endpackage

// File: rtl/gearbox_130b8b.sv
// rtl/gearbox_130b8b.sv - 130-bit block to 8-bit stream gearbox with sync header insertion
module gearbox_130b8b
  import enc128b130b_pkg::*;
(
  input  logic              clk_1G,
  input  logic              rst_1G,
  input  logic [BYTE_W-1:0] scram_data_in,
  input  logic              in_valid,
  input  logic [HDR_W-1:0]  sync_hdr,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  output logic [POS_W-1:0]  blk_pos,
  output logic              hdr_err
);

  // Registered state: buffer contents, fill level, block position and outputs
  logic [BUF_W-1:0]  gbuf_q, gbuf_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [POS_W-1:0]  blk_pos_q, blk_pos_d;
  logic [BYTE_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              hdr_err_q, hdr_err_d;

  // Per-cycle intermediates
  logic              drain;
  logic [LVL_W-1:0]  base;
  logic              accept;
  logic              blk_start;
  logic [BLK0_W-1:0] ins_bits;
  logic [LVL_W-1:0]  ins_len;
  logic [BUF_W-1:0]  kept;
  logic [BUF_W-1:0]  ins_vec;

  // Drain decision and back-pressure, derived only from the registered level
  always_comb begin
    drain    = 1'b0;
    base     = level_q;
    in_ready = 1'b0;
    if (level_q >= LVL_W'(BYTE_W)) begin
      drain = 1'b1;
      base  = level_q - LVL_W'(BYTE_W);
    end
    // Room must exist for the widest append (a header byte) after this cycle's drain
    in_ready = ((6'(base) + 6'(BLK0_W)) <= 6'(BUF_W));
  end

  // Buffer shift, bit insertion at the post-drain level, and next-state for all flops
  always_comb begin
    accept    = in_valid && in_ready;
    blk_start = (blk_pos_q == '0);

    if (blk_start) begin
      ins_bits = {scram_data_in, sync_hdr};
      ins_len  = LVL_W'(BLK0_W);
    end else begin
      ins_bits = {{HDR_W{1'b0}}, scram_data_in};
      ins_len  = LVL_W'(BYTE_W);
    end

    // Bits above the level are always zero, so OR-ing the new bits in is safe
    kept    = drain ? (gbuf_q >> BYTE_W) : gbuf_q;
    ins_vec = {{(BUF_W-BLK0_W){1'b0}}, ins_bits} << base;

    gbuf_d      = kept;
    level_d     = base;
    blk_pos_d   = blk_pos_q;
    hdr_err_d   = 1'b0;
    out_valid_d = drain;
    out_data_d  = out_data_q;

    if (drain) begin
      out_data_d = gbuf_q[BYTE_W-1:0];
    end

    if (accept) begin
      gbuf_d    = kept | ins_vec;
      level_d   = base + ins_len;
      hdr_err_d = blk_start && !hdr_legal(sync_hdr);
      if (blk_pos_q == POS_W'(BYTES_PER_BLK - 1)) begin
        blk_pos_d = '0;
      end else begin
        blk_pos_d = blk_pos_q + 1'b1;
      end
    end
  end

  // State register; reset discards any partially sent block
  always_ff @(posedge clk_1G or negedge rst_1G) begin
    if (!rst_1G) begin
      gbuf_q      <= '0;
      level_q     <= '0;
      blk_pos_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      gbuf_q      <= gbuf_d;
      level_q     <= level_d;
      blk_pos_q   <= blk_pos_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      hdr_err_q   <= hdr_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign blk_pos   = blk_pos_q;
  assign hdr_err   = hdr_err_q;

endmodule
